// File: rtl/fifo_read_stream.sv
// rtl/fifo_read_stream.sv - FIFO read-side drain with 3-entry skid buffer and burst-framed valid/ready stream
module fifo_read_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] dout_b,
  output logic                  ren_b,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int DEPTH = 3;
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  // Skid buffer storage: circular, head/tail run 0..2
  logic [FIFO_WIDTH-1:0] data_q [DEPTH];
  logic [FIFO_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      last_q, last_d;
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [IDX_W-1:0]      cap_idx_q, cap_idx_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit-based read issue: never request more than the buffer can still hold,
  // counting the word already in flight from the previous cycle
  always_comb begin
    ren_b = rst && !empty && !flush &&
            (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  end

  // Stream outputs come straight from the buffer head
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    m_data     = m_valid ? data_q[head_q] : '0;
    m_last     = m_valid && last_q[head_q];
    word_count = word_count_q;
  end

  // Next-state: capture returning read data, pop on transfer, flush clears the pipeline
  always_comb begin
    push         = inflight_q && !flush;
    pop          = m_valid && m_ready;
    data_d       = data_q;
    last_d       = last_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    cap_idx_d    = cap_idx_q;
    word_count_d = word_count_q;
    inflight_d   = ren_b;

    if (push) begin
      data_d[tail_q] = dout_b;
      last_d[tail_q] = (cap_idx_q == LAST_IDX);
      tail_d         = ptr_inc(tail_q);
      cap_idx_d      = (cap_idx_q == LAST_IDX) ? '0 : cap_idx_q + 1'b1;
    end

    if (pop) begin
      head_d       = ptr_inc(head_q);
      word_count_d = word_count_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // Flush drops buffered words and the in-flight word; transfer count is kept
    if (flush) begin
      head_d    = 2'd0;
      tail_d    = 2'd0;
      occ_d     = 2'd0;
      cap_idx_d = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_b or negedge rst) begin
    if (!rst) begin
      data_q       <= '{default: '0};
      last_q       <= '0;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      cap_idx_q    <= '0;
      word_count_q <= '0;
    end else begin
      data_q       <= data_d;
      last_q       <= last_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      cap_idx_q    <= cap_idx_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
